// File: rtl/mcu_pixel_path_pkg.sv
// mcu_pixel_path_pkg: shared command codes, pixel format and RGB444 field positions
package mcu_pixel_path_pkg;
  localparam logic [7:0] CMD_RESET_WRITE_PTR = 8'h01;
  localparam logic [7:0] CMD_START_VGA = 8'h02;
  localparam int PIXEL_WIDTH = 12;
  localparam int R_MSB = 11;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;
  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  function automatic pixel_t pack_rgb(input logic [7:0] rg, input logic [3:0] b);
    pixel_t p;
    p[R_MSB:G_LSB] = rg;
    p[B_MSB:B_LSB] = b;
    return p;
  endfunction
endpackage

// File: rtl/mcu_pixel_path_clock_divider_core.sv
// clock_divider_core: toggles out every div clk cycles (period 2*div); div==0 holds out low
// Ports: clk, rst (async, active-high), div (half-period), out (divided clock)
module clock_divider_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] div,
  output logic         out
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (div == '0) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (cnt == div - 1'b1) begin
      cnt <= '0;
      out <= ~out;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mcu_pixel_path.sv
// mcu_pixel_path: MCU byte bus ingress -> RGB444 pixel assembly -> pixel memory with scanout read, plus clock divider
// Ports: system_clock/reset (async, active-high); div -> divided_clock;
//   mcu_bus_clock/mcu_bus/mcu_bus_command_data in -> mcu_command_clock/command_byte, mcu_pixel_clock/pixel_data out;
//   framebuffer_read_pointer -> read_data (1-cycle latency, 0 when out of range)
module mcu_pixel_path
  import mcu_pixel_path_pkg::*;
#(
  parameter int MEM_DEPTH = 4096,
  parameter int ADDR_WIDTH = 22,
  parameter int DIV_WIDTH = 8
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div,
  output logic                  divided_clock,
  input  logic                  mcu_bus_clock,
  input  logic [7:0]            mcu_bus,
  input  logic                  mcu_bus_command_data,
  output logic                  mcu_command_clock,
  output logic [7:0]            command_byte,
  output logic                  mcu_pixel_clock,
  output logic [11:0]           pixel_data,
  input  logic [ADDR_WIDTH-1:0] framebuffer_read_pointer,
  output logic [11:0]           read_data
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  logic [2:0] sync;
  logic rise, phase, in_range;
  logic [7:0] hi;
  logic [IDX_W-1:0] wp;
  pixel_t mem [MEM_DEPTH];
  clock_divider_core #(.W(DIV_WIDTH)) u_div (
    .clk(system_clock),
    .rst(reset),
    .div(div),
    .out(divided_clock)
  );
  // sync[1:0] is the 2-FF synchroniser, sync[2] the edge-detect stage
  always_ff @(posedge system_clock or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[1:0], mcu_bus_clock};
  assign rise = sync[1] & ~sync[2];
  always_ff @(posedge system_clock or posedge reset)
    if (reset) begin
      mcu_command_clock <= 1'b0;
      mcu_pixel_clock <= 1'b0;
      command_byte <= '0;
      pixel_data <= '0;
      phase <= 1'b0;
      hi <= '0;
      wp <= '0;
    end else begin
      mcu_command_clock <= rise & mcu_bus_command_data;
      mcu_pixel_clock <= rise & ~mcu_bus_command_data & phase;
      if (mcu_pixel_clock) wp <= wp + 1'b1;
      if (rise) begin
        if (mcu_bus_command_data) begin
          command_byte <= mcu_bus;
          phase <= 1'b0;
          if (mcu_bus == CMD_RESET_WRITE_PTR) wp <= '0;
        end else if (!phase) begin
          hi <= mcu_bus;
          phase <= 1'b1;
        end else begin
          pixel_data <= pack_rgb(hi, mcu_bus[3:0]);
          phase <= 1'b0;
        end
      end
    end
  // memory is never cleared; writes trail the assembly by one cycle so pixel_data is already valid
  always_ff @(posedge system_clock)
    if (mcu_pixel_clock) mem[wp] <= pixel_data;
  assign in_range = ~|framebuffer_read_pointer[ADDR_WIDTH-1:IDX_W];
  always_ff @(posedge system_clock or posedge reset)
    if (reset) read_data <= '0;
    else read_data <= in_range ? mem[framebuffer_read_pointer[IDX_W-1:0]] : '0;
endmodule

// File: tb/tb_mcu_pixel_path.sv
// tb_mcu_pixel_path: directed + randomized checks of mcu_pixel_path against a byte-stream reference model
module tb_mcu_pixel_path;
  import mcu_pixel_path_pkg::*;
  localparam int DEPTH = 4096;
  logic system_clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] div = 8'd4;
  logic divided_clock;
  logic mcu_bus_clock = 1'b0;
  logic [7:0] mcu_bus = 8'h00;
  logic mcu_bus_command_data = 1'b0;
  logic mcu_command_clock;
  logic [7:0] command_byte;
  logic mcu_pixel_clock;
  logic [11:0] pixel_data;
  logic [21:0] framebuffer_read_pointer = '0;
  logic [11:0] read_data;
  int checks = 0;
  int errors = 0;
  logic [11:0] mmem [DEPTH];
  int mwp = 0;
  bit mphase = 1'b0;
  logic [7:0] mhi = 8'h00;
  logic [7:0] mcmd = 8'h00;
  logic [11:0] mpix = 12'h000;

  mcu_pixel_path dut (
    .system_clock(system_clock),
    .reset(reset),
    .div(div),
    .divided_clock(divided_clock),
    .mcu_bus_clock(mcu_bus_clock),
    .mcu_bus(mcu_bus),
    .mcu_bus_command_data(mcu_bus_command_data),
    .mcu_command_clock(mcu_command_clock),
    .command_byte(command_byte),
    .mcu_pixel_clock(mcu_pixel_clock),
    .pixel_data(pixel_data),
    .framebuffer_read_pointer(framebuffer_read_pointer),
    .read_data(read_data)
  );

  always #5 system_clock = ~system_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge system_clock);
    #1;
  endtask

  // strobe high for 3 cycles then low for 3; pulse positions are cycle indices after strobe rises
  task automatic send_byte(input logic [7:0] b, input bit cmd, output int nc, output int np,
                           output int ca, output int pa);
    nc = 0; np = 0; ca = -1; pa = -1;
    mcu_bus = b;
    mcu_bus_command_data = cmd;
    mcu_bus_clock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (mcu_command_clock) begin nc++; if (ca < 0) ca = i; end
      if (mcu_pixel_clock) begin np++; if (pa < 0) pa = i; end
      if (i == 2) mcu_bus_clock = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit cmd);
    int nc, np, ca, pa;
    bit exp_pix;
    exp_pix = !cmd && mphase;
    send_byte(b, cmd, nc, np, ca, pa);
    if (cmd) begin
      mcmd = b;
      mphase = 1'b0;
      if (b == 8'h01) mwp = 0;
    end else if (!mphase) begin
      mhi = b;
      mphase = 1'b1;
    end else begin
      mpix = {mhi, b[3:0]};
      mmem[mwp] = mpix;
      mwp = (mwp + 1) % DEPTH;
      mphase = 1'b0;
    end
    check("cmd_pulse_count", nc, cmd ? 1 : 0);
    check("cmd_pulse_cycle", ca, cmd ? 2 : -1);
    check("pix_pulse_count", np, exp_pix ? 1 : 0);
    check("pix_pulse_cycle", pa, exp_pix ? 2 : -1);
    check("command_byte", command_byte, mcmd);
    check("pixel_data", pixel_data, mpix);
  endtask

  task automatic rd(input logic [21:0] a, input logic [11:0] exp, input string tag);
    framebuffer_read_pointer = a;
    cycle();
    check(tag, read_data, exp);
  endtask

  task automatic model_reset();
    mphase = 1'b0; mwp = 0; mcmd = 8'h00; mpix = 12'h000;
  endtask

  initial begin
    int d;
    logic [21:0] a;
    repeat (3) cycle();
    check("rst_divided_clock", divided_clock, 0);
    check("rst_cmd_pulse", mcu_command_clock, 0);
    check("rst_pix_pulse", mcu_pixel_clock, 0);
    check("rst_command_byte", command_byte, 0);
    check("rst_pixel_data", pixel_data, 0);
    check("rst_read_data", read_data, 0);
    reset = 1'b0;
    // after k edges from reset release the divided clock equals floor(k/div) mod 2
    for (int k = 1; k <= 40; k++) begin
      cycle();
      check("div4", divided_clock, (k / 4) % 2);
    end
    div = 8'd0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("div0", divided_clock, 0);
    end
    d = $urandom_range(1, 7);
    reset = 1'b1;
    div = d[7:0];
    cycle();
    reset = 1'b0;
    for (int k = 1; k <= 6 * d; k++) begin
      cycle();
      check("div_rand", divided_clock, (k / d) % 2);
    end
    div = 8'd0;
    xfer(CMD_START_VGA, 1'b1);
    xfer(8'hA5, 1'b0);
    xfer(8'hF3, 1'b0);
    check("pixel_a53", pixel_data, 12'hA53);
    rd(22'd0, 12'hA53, "read_a53");
    xfer(8'h12, 1'b0);
    xfer(CMD_RESET_WRITE_PTR, 1'b1);
    xfer(8'h34, 1'b0);
    xfer(8'h56, 1'b0);
    rd(22'd0, 12'h346, "read_346");
    xfer(8'h77, 1'b0);
    reset = 1'b1;
    cycle();
    cycle();
    model_reset();
    check("midrst_cmd_pulse", mcu_command_clock, 0);
    check("midrst_pix_pulse", mcu_pixel_clock, 0);
    check("midrst_command_byte", command_byte, 0);
    check("midrst_pixel_data", pixel_data, 0);
    check("midrst_read_data", read_data, 0);
    check("midrst_divided_clock", divided_clock, 0);
    reset = 1'b0;
    xfer(8'h9C, 1'b0);
    xfer(8'h4B, 1'b0);
    check("pixel_9cb", pixel_data, 12'h9CB);
    rd(22'd0, 12'h9CB, "read_9cb");
    xfer(CMD_RESET_WRITE_PTR, 1'b1);
    for (int n = 0; n <= DEPTH; n++) begin
      xfer(8'($urandom), 1'b0);
      xfer(8'($urandom), 1'b0);
    end
    check("wrap_ptr_model", mwp, 1);
    rd(22'd0, mpix, "read_wrap_last");
    rd(22'd1, mmem[1], "read_addr1");
    rd(22'(DEPTH - 1), mmem[DEPTH - 1], "read_top");
    for (int n = 0; n < 20; n++) begin
      a = 22'($urandom_range(0, DEPTH - 1));
      rd(a, mmem[a[11:0]], "read_rand");
    end
    rd(22'(DEPTH), 12'h000, "read_oor_depth");
    for (int n = 0; n < 5; n++) rd(22'($urandom_range(DEPTH + 1, 22'h3FFFFF)), 12'h000, "read_oor_rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
